// File: rtl/mirfak_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring shift-subtract, one quotient bit per cycle.
// Define MIRFAK_DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
//
// state | meaning
// IDLE  | waiting for div_enable; operands sampled here only
// BUSY  | 32 shift-subtract iterations
// DONE  | div_ack high for one cycle, then back to IDLE
module mirfak_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] div_op1,
    input  logic [31:0] div_op2,
    input  logic [1:0]  div_cmd,
    input  logic        div_enable,
    input  logic        div_abort,
    output logic [31:0] div_result,
    output logic        div_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t      state;
    logic [4:0]  iter_cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [1:0]  cmd_q;
    logic        neg_q;
    logic        neg_r;

    logic        is_signed;
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] final_res;
    logic        special;
    logic [31:0] special_res;

    assign is_signed = ~div_cmd[0];
    assign op1_neg   = is_signed & div_op1[31];
    assign op2_neg   = is_signed & div_op2[31];
    assign op1_mag   = op1_neg ? (32'd0 - div_op1) : div_op1;
    assign op2_mag   = op2_neg ? (32'd0 - div_op2) : div_op2;

    // The remainder never exceeds the divisor, so only the shifted trial needs the 33rd bit.
    assign rem_sh  = {rem, quo[31]};
    assign trial   = rem_sh - {1'b0, dvs};
    assign rem_nxt = trial[32] ? rem_sh[31:0] : trial[31:0];
    assign quo_nxt = {quo[30:0], ~trial[32]};

    assign q_fix     = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
    assign r_fix     = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
    assign final_res = cmd_q[1] ? r_fix : q_fix;

`ifdef MIRFAK_DIV_FAST_SPECIAL_EN
    logic div_zero;
    logic sgn_ovf;
    assign div_zero    = (div_op2 == 32'd0);
    assign sgn_ovf     = is_signed && (div_op1 == 32'h8000_0000) && (div_op2 == 32'hFFFF_FFFF);
    assign special     = div_zero | sgn_ovf;
    assign special_res = div_zero ? (div_cmd[1] ? div_op1 : 32'hFFFF_FFFF)
                                  : (div_cmd[1] ? 32'd0 : 32'h8000_0000);
`else
    assign special     = 1'b0;
    assign special_res = 32'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            iter_cnt   <= 5'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            dvs        <= 32'd0;
            cmd_q      <= 2'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_result <= 32'd0;
            div_ack    <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (div_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (div_enable) begin
                            if (special) begin
                                div_result <= special_res;
                                div_ack    <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                quo      <= op1_mag;
                                rem      <= 32'd0;
                                dvs      <= op2_mag;
                                cmd_q    <= div_cmd;
                                // Divide-by-zero keeps the all-ones quotient unsigned.
                                neg_q    <= (op1_neg ^ op2_neg) && (div_op2 != 32'd0);
                                neg_r    <= op1_neg;
                                iter_cnt <= 5'd0;
                                state    <= ST_BUSY;
                            end
                        end
                    end
                    ST_BUSY: begin
                        quo      <= quo_nxt;
                        rem      <= rem_nxt;
                        iter_cnt <= iter_cnt + 5'd1;
                        if (iter_cnt == 5'd31) begin
                            div_result <= final_res;
                            div_ack    <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mirfak_div_unit.sv
// Self-checking bench for mirfak_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mirfak_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] div_op1 = '0;
    logic [31:0] div_op2 = '0;
    logic [1:0]  div_cmd = '0;
    logic        div_enable = 1'b0;
    logic        div_abort = 1'b0;
    logic [31:0] div_result;
    logic        div_ack;

    int errors = 0;
    int checks = 0;

    mirfak_div_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .div_op1(div_op1), .div_op2(div_op2),
        .div_cmd(div_cmd), .div_enable(div_enable), .div_abort(div_abort),
        .div_result(div_result), .div_ack(div_ack)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_div(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return cmd[1] ? a : 32'hFFFF_FFFF;
        if (!cmd[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return cmd[1] ? 32'd0 : 32'h8000_0000;
        case (cmd)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
`ifdef MIRFAK_DIV_FAST_SPECIAL_EN
        if (b == 32'd0 || (!cmd[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op from IDLE, scrambles operands while busy, checks latency, result, one-cycle ack.
    task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        int lat;
        exp = ref_div(cmd, a, b);
        div_cmd = cmd; div_op1 = a; div_op2 = b; div_enable = 1'b1;
        lat = 0; got = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (div_ack) begin lat = i; got = div_result; break; end
            div_op1 = $urandom; div_op2 = $urandom; div_cmd = 2'($urandom_range(0, 3));
        end
        div_enable = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_latency(cmd, a, b)));
        chk({tag, " result"}, got, exp);
        @(posedge clk_i); #1;
        chk({tag, " ack one cycle"}, 32'(div_ack), 32'd0);
        chk({tag, " result held"}, div_result, exp);
    endtask

    initial begin
        int bad;
        int lat;
        logic [31:0] got;
        logic [1:0] rc;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset ack", 32'(div_ack), 32'd0);
        chk("reset result", div_result, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
        run_op(2'b01, 32'hFFFF_FFFF, 32'h10, "divu ffffffff/16");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, "remu ffffffff/16");
        run_op(2'b00, 32'h1234_5678, 32'd0, "div by zero");
        run_op(2'b10, 32'h1234_5678, 32'd0, "rem by zero");
        run_op(2'b01, 32'h1234_5678, 32'd0, "divu by zero");
        run_op(2'b10, 32'hF234_5678, 32'd0, "rem neg by zero");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");

        // Abort at C10, new DIVU 100/7 issued at C12.
        bad = 0;
        div_cmd = 2'b01; div_op1 = 32'd100; div_op2 = 32'd7; div_enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin @(posedge clk_i); #1; if (div_ack) bad++; end
        div_abort = 1'b1;
        @(posedge clk_i); #1; if (div_ack) bad++;
        div_abort = 1'b0; div_enable = 1'b0;
        @(posedge clk_i); #1; if (div_ack) bad++;
        div_enable = 1'b1;
        lat = 0; got = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (div_ack) begin
                if (12 + i <= 40) bad++;
                lat = i; got = div_result;
                break;
            end
        end
        div_enable = 1'b0;
        chk("abort no ack", 32'(bad), 32'd0);
        chk("after abort latency", 32'(lat), 32'd33);
        chk("after abort divu", got, 32'h0000_000E);
        @(posedge clk_i); #1;
        run_op(2'b11, 32'd100, 32'd7, "remu 100/7");

        // Back-to-back with enable held: DIV 20/3 then REM 20/3.
        for (int pass = 0; pass < 2; pass++) begin
            div_cmd = 2'b00; div_op1 = 32'd20; div_op2 = 32'd3; div_enable = 1'b1;
            lat = 0; got = '0;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk_i); #1;
                if (div_ack) begin lat = i; got = div_result; break; end
            end
            chk("b2b first latency", 32'(lat), 32'd33);
            chk("b2b div 20/3", got, 32'd6);
            div_cmd = 2'b10;
            if (pass == 0) begin
                lat = 0; got = '0;
                for (int i = 1; i <= 40; i++) begin
                    @(posedge clk_i); #1;
                    if (div_ack) begin lat = i; got = div_result; break; end
                end
                chk("b2b second latency", 32'(lat), 32'd34);
                chk("b2b rem 20/3", got, 32'd2);
                div_enable = 1'b0;
                @(posedge clk_i); #1;
            end else begin
                repeat (12) @(posedge clk_i);
                #2;
                rst_i = 1'b0;
                #1;
                chk("mid-op reset ack", 32'(div_ack), 32'd0);
                chk("mid-op reset result", div_result, 32'd0);
                div_enable = 1'b0;
                @(posedge clk_i); #1;
                rst_i = 1'b1;
                bad = 0;
                for (int i = 0; i < 40; i++) begin @(posedge clk_i); #1; if (div_ack) bad++; end
                chk("no ack after reset", 32'(bad), 32'd0);
            end
        end

        for (int n = 0; n < 60; n++) begin
            rc = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(rc, ra, rb, $sformatf("rand%0d cmd%0d %h/%h", n, rc, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
